misao_mem_arbiter: RTL and testbench



---
 rtl/misao_mem_pkg.sv | 16 +
 rtl/misao_arb_pick.sv | 38 +++
 rtl/misao_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_misao_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/misao_mem_pkg.sv
// Shared types and constants for the MISA-O memory port arbiter.
package misao_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_LOAD = 1'b1;

endpackage

// File: rtl/misao_arb_pick.sv
// Winner select for the shared memory port: fixed priority to the core, with a
// burst limit after which a waiting loader request is forced through.
module misao_arb_pick
    import misao_mem_pkg::*;
#(
    parameter int MAX_BURST = 2,
    parameter int CNT_W     = 2
) (
    input  logic             m0_req,
    input  logic             m1_req,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic [1:0]       grant,
    output logic [CNT_W-1:0] burst_next
);

    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    always_comb begin
        grant      = 2'b00;
        burst_next = burst_cnt;
        if (m0_req && m1_req) begin
            if (burst_cnt < BURST_MAX) begin
                grant      = 2'b01;
                burst_next = burst_cnt + CNT_W'(1);
            end else begin
                grant      = 2'b10;
                burst_next = '0;
            end
        end else if (m0_req) begin
            grant      = 2'b01;
            burst_next = '0;
        end else if (m1_req) begin
            grant      = 2'b10;
            burst_next = '0;
        end
    end

endmodule

// File: rtl/misao_mem_arbiter.sv
// MISA-O memory port arbiter: shares one nibble-wide memory port between the
// core (port 0) and the program loader / debug port (port 1).
//
// state  | meaning
// IDLE   | arbitrate; winner's gnt driven combinationally this cycle
// ACCESS | memory strobe held with latched request, WAIT_CYCLES+1 cycles
// DONE   | owner's done/rdata pulse, bus released, no grant
module misao_mem_arbiter
    import misao_mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 4,
    parameter int WAIT_CYCLES = 1,
    parameter int MAX_BURST   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int          CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [2:0]  WAIT_INIT = 3'(WAIT_CYCLES);

    arb_state_t        state_q, state_d;
    logic [1:0]        grant;
    logic [CNT_W-1:0]  burst_cnt, burst_next;
    logic [2:0]        wait_cnt;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    misao_arb_pick #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_pick (
        .m0_req     (m0_req),
        .m1_req     (m1_req),
        .burst_cnt  (burst_cnt),
        .grant      (grant),
        .burst_next (burst_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        m0_done   = 1'b0;
        m1_done   = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        mem_en    = 1'b0;
        mem_rw    = MEM_READ;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                // gnt is combinational, so keep it quiet while reset is held
                if (!rst) begin
                    m0_gnt = grant[0];
                    m1_gnt = grant[1];
                end
                if (|grant) state_d = ACCESS;
            end
            ACCESS: begin
                mem_en   = 1'b1;
                mem_rw   = we_q ? MEM_WRITE : MEM_READ;
                mem_addr = addr_q;
                if (we_q) mem_wdata = wdata_q;
                if (wait_cnt == '0) state_d = DONE;
            end
            DONE: begin
                if (owner_q == REQ_LOAD) begin
                    m1_done  = 1'b1;
                    m1_rdata = rdata_q;
                end else begin
                    m0_done  = 1'b1;
                    m0_rdata = rdata_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q   <= REQ_CORE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            wait_cnt  <= '0;
            burst_cnt <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|grant) begin
                        owner_q   <= grant[1] ? REQ_LOAD : REQ_CORE;
                        we_q      <= grant[1] ? m1_we : m0_we;
                        addr_q    <= grant[1] ? m1_addr : m0_addr;
                        wdata_q   <= grant[1] ? m1_wdata : m0_wdata;
                        wait_cnt  <= WAIT_INIT;
                        burst_cnt <= burst_next;
                    end
                end
                ACCESS: begin
                    if (wait_cnt == '0) begin
                        rdata_q <= we_q ? '0 : mem_rdata;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state_q != IDLE);
    assign owner = owner_q;

endmodule

// File: tb/tb_misao_mem_arbiter.sv
// Bench for misao_mem_arbiter: two instances (one and zero wait states) share
// stimulus and are each compared every cycle against a timeline reference.
`timescale 1ns/1ps
module tb_misao_mem_arbiter;

    localparam int NI        = 2;
    localparam int WAIT0     = 1;
    localparam int WAIT1     = 0;
    localparam int MAX_BURST = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [15:0] m0_addr = '0;
    logic [3:0]  m0_wdata = '0;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [15:0] m1_addr = '0;
    logic [3:0]  m1_wdata = '0;

    logic        o_m0_gnt [NI], o_m0_done [NI], o_m1_gnt [NI], o_m1_done [NI];
    logic [3:0]  o_m0_rdata [NI], o_m1_rdata [NI];
    logic        mem_en [NI], mem_rw [NI], busy [NI], owner [NI];
    logic [15:0] mem_addr [NI];
    logic [3:0]  mem_wdata [NI], mem_rdata [NI];

    logic [3:0]  rom [256];

    assign mem_rdata[0] = rom[mem_addr[0][7:0]];
    assign mem_rdata[1] = rom[mem_addr[1][7:0]];

    always #5 clk = ~clk;

    misao_mem_arbiter #(.ADDR_W(16), .DATA_W(4), .WAIT_CYCLES(WAIT0), .MAX_BURST(MAX_BURST)) dut_w1 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(o_m0_gnt[0]), .m0_done(o_m0_done[0]), .m0_rdata(o_m0_rdata[0]),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(o_m1_gnt[0]), .m1_done(o_m1_done[0]), .m1_rdata(o_m1_rdata[0]),
        .mem_en(mem_en[0]), .mem_rw(mem_rw[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
        .busy(busy[0]), .owner(owner[0])
    );

    misao_mem_arbiter #(.ADDR_W(16), .DATA_W(4), .WAIT_CYCLES(WAIT1), .MAX_BURST(MAX_BURST)) dut_w0 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(o_m0_gnt[1]), .m0_done(o_m0_done[1]), .m0_rdata(o_m0_rdata[1]),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(o_m1_gnt[1]), .m1_done(o_m1_done[1]), .m1_rdata(o_m1_rdata[1]),
        .mem_en(mem_en[1]), .mem_rw(mem_rw[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
        .busy(busy[1]), .owner(owner[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: an access granted at cycle g strobes memory in cycles
    // g+1..g+W+1, pulses done at g+W+2 and the port is free again at g+W+3.
    int          act [NI], start [NI], own [NI], burst [NI];
    logic        mwe [NI];
    logic [15:0] maddr [NI];
    logic [3:0]  mwd [NI];
    int          glog0 [$], glog1 [$], dlog1 [$];

    function automatic int wait_of(input int i);
        return (i == 0) ? WAIT0 : WAIT1;
    endfunction

    task automatic model_cycle(input int i);
        int    w, k, win;
        logic  e_g0, e_g1, e_d0, e_d1, e_busy, e_en, e_rw, e_own;
        string p;
        w = wait_of(i);
        p = (i == 0) ? "w1" : "w0";
        e_g0 = 0; e_g1 = 0; e_d0 = 0; e_d1 = 0; e_busy = 0; e_en = 0; e_rw = 1;
        if (rst) begin
            act[i] = 0; own[i] = 0; burst[i] = 0;
            check($sformatf("%s.rst_addr", p), mem_addr[i], 0);
            check($sformatf("%s.rst_wdata", p), mem_wdata[i], 0);
            check($sformatf("%s.rst_rdata", p), {o_m0_rdata[i], o_m1_rdata[i]}, 0);
        end
        e_own = own[i][0];
        if (!rst && act[i] != 0) begin
            k = cyc - start[i];
            e_busy = 1;
            if (k <= w + 1) begin
                e_en = 1;
                e_rw = !mwe[i];
                check($sformatf("%s.mem_addr", p), mem_addr[i], maddr[i]);
                check($sformatf("%s.mem_wdata", p), mem_wdata[i], mwe[i] ? mwd[i] : 4'h0);
            end else begin
                if (own[i] == 0) begin
                    e_d0 = 1;
                    check($sformatf("%s.m0_rdata", p), o_m0_rdata[i], mwe[i] ? 4'h0 : rom[maddr[i][7:0]]);
                end else begin
                    e_d1 = 1;
                    check($sformatf("%s.m1_rdata", p), o_m1_rdata[i], mwe[i] ? 4'h0 : rom[maddr[i][7:0]]);
                end
                act[i] = 0;
            end
        end else if (!rst && (m0_req || m1_req)) begin
            if (m0_req && m1_req) begin
                if (burst[i] < MAX_BURST) begin win = 0; burst[i]++; end
                else begin win = 1; burst[i] = 0; end
            end else begin
                win = m1_req ? 1 : 0;
                burst[i] = 0;
            end
            if (win == 0) e_g0 = 1; else e_g1 = 1;
            act[i] = 1; start[i] = cyc; own[i] = win;
            mwe[i]   = (win == 0) ? m0_we : m1_we;
            maddr[i] = (win == 0) ? m0_addr : m1_addr;
            mwd[i]   = (win == 0) ? m0_wdata : m1_wdata;
        end
        check($sformatf("%s.gnt", p), {o_m0_gnt[i], o_m1_gnt[i]}, {e_g0, e_g1});
        check($sformatf("%s.done", p), {o_m0_done[i], o_m1_done[i]}, {e_d0, e_d1});
        check($sformatf("%s.busy", p), busy[i], e_busy);
        check($sformatf("%s.mem_en", p), mem_en[i], e_en);
        check($sformatf("%s.mem_rw", p), mem_rw[i], e_rw);
        check($sformatf("%s.owner", p), owner[i], e_own);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) model_cycle(i);
        if (o_m0_gnt[0]) glog0.push_back(0);
        if (o_m1_gnt[0]) glog0.push_back(1);
        if (o_m0_gnt[1]) glog1.push_back(0);
        if (o_m1_gnt[1]) glog1.push_back(1);
        if (o_m0_done[1]) dlog1.push_back(cyc);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        m0_req = 0; m1_req = 0;
        repeat (n) step();
    endtask

    int exp_order [6] = '{0, 0, 1, 0, 0, 1};
    int n0, n1, guard;

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 4'($urandom);
        rom[8'h34] = 4'hA;
        for (int i = 0; i < NI; i++) begin
            act[i] = 0; start[i] = 0; own[i] = 0; burst[i] = 0;
            mwe[i] = 0; maddr[i] = '0; mwd[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 0;
        idle(2);

        // core read of 0x1234, memory returns 0xA
        m0_req = 1; m0_we = 0; m0_addr = 16'h1234;
        @(negedge clk); check("rd.gnt", o_m0_gnt[0], 1);
        step(); m0_req = 0;
        @(negedge clk); check("rd.acc1", {mem_en[0], mem_rw[0], mem_addr[0]}, {2'b11, 16'h1234});
        step();
        @(negedge clk); check("rd.acc2", {mem_en[0], mem_rw[0], mem_addr[0]}, {2'b11, 16'h1234});
        step();
        @(negedge clk); check("rd.done", {o_m0_done[0], o_m0_rdata[0]}, {1'b1, 4'hA});
        step();
        @(negedge clk); check("rd.idle", busy[0], 0);
        idle(2);

        // loader write of 0x5 to 0x00F0
        m1_req = 1; m1_we = 1; m1_addr = 16'h00F0; m1_wdata = 4'h5;
        step(); m1_req = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); check("wr.acc", {mem_en[0], mem_rw[0], mem_wdata[0]}, {2'b10, 4'h5});
            step();
        end
        @(negedge clk); check("wr.done", {o_m1_done[0], o_m1_rdata[0], owner[0]}, {1'b1, 4'h0, 1'b1});
        idle(3);

        // contention with both requests held
        glog0.delete(); glog1.delete();
        m0_req = 1; m0_we = 0; m1_req = 1; m1_we = 0;
        guard = 0;
        while (glog0.size() < 6 && guard < 40) begin
            m0_addr = 16'($urandom); m1_addr = 16'($urandom);
            step(); guard++;
        end
        idle(6);
        check("ct.count0", glog0.size() >= 6, 1);
        check("ct.count1", glog1.size() >= 6, 1);
        for (int g = 0; g < 6; g++) begin
            if (g < glog0.size()) check($sformatf("ct.w1.order%0d", g), glog0[g], exp_order[g]);
            if (g < glog1.size()) check($sformatf("ct.w0.order%0d", g), glog1[g], exp_order[g]);
        end

        // back-to-back reads of 0x0000 and 0x0001
        dlog1.delete();
        m0_req = 1; m0_we = 0; m0_addr = 16'h0000;
        step(); m0_addr = 16'h0001;
        repeat (3) step();
        idle(4);
        check("b2b.dones", dlog1.size(), 2);
        if (dlog1.size() >= 2) check("b2b.spacing", dlog1[1] - dlog1[0], 3);

        // reset during the second access cycle
        m0_req = 1; m0_we = 0; m0_addr = 16'h0042;
        step(); m0_req = 0;
        step();
        rst = 1;
        #1 check("rs.mem", {mem_en[0], mem_rw[0], busy[0]}, 3'b010);
        step(); rst = 0;
        m1_req = 1; m1_we = 0; m1_addr = 16'h0077;
        @(negedge clk); check("rs.m1_gnt", {o_m1_gnt[0], o_m1_gnt[1]}, 2'b11);
        step(); m1_req = 0;
        idle(5);

        // loader request withdrawn while the core access is in progress
        n0 = glog0.size(); n1 = glog1.size();
        m0_req = 1; m0_we = 0; m0_addr = 16'h0010;
        step(); m0_req = 0;
        step(); m1_req = 1; m1_addr = 16'h0BAD;
        step(); m1_req = 0;
        idle(5);
        check("wd.grants_w1", glog0.size() - n0, 1);
        check("wd.grants_w0", glog1.size() - n1, 1);

        // randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            m0_req   = ($urandom_range(0, 2) != 0);
            m1_req   = ($urandom_range(0, 2) != 0);
            m0_we    = 1'($urandom);
            m1_we    = 1'($urandom);
            m0_addr  = 16'($urandom);
            m1_addr  = 16'($urandom);
            m0_wdata = 4'($urandom);
            m1_wdata = 4'($urandom);
            rst      = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 0;
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
